// File: rtl/asip_isa_pkg.sv
// ASIP instruction-set definitions shared by the encoder, the decoder and bench models.
// Word layout: opcode [15:12], register [11:8], immediate [7:0].
package asip_isa_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;

    typedef enum logic [2:0] {
        CLS_LDI   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_JMP   = 3'd2,
        CLS_JCOND = 3'd3,
        CLS_STORE = 3'd4,
        CLS_LOAD  = 3'd5,
        CLS_HALT  = 3'd6,
        CLS_RSVD  = 3'd7
    } instr_class_e;

    localparam logic [3:0] OP_LDI   = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_JCOND = 4'b1001;
    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic [OPC_MSB:0] pack_word(input logic [3:0]       opc,
                                                   input logic [3:0]       reg_idx,
                                                   input logic [IMM_MSB:0] imm);
        logic [OPC_MSB:0] w;
        w                  = '0;
        w[OPC_MSB:OPC_LSB] = opc;
        w[REG_MSB:REG_LSB] = reg_idx;
        w[IMM_MSB:0]       = imm;
        return w;
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Field-beat stream in, instruction-memory write port out.
// Latency: n/a (wires only).
// Backpressure: producer holds in_valid and fields until it sees in_ready at a clock edge.
interface instr_stream_encoder_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [2:0]        in_alu_op;
    logic [3:0]        in_reg;
    logic [7:0]        in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [N-1:0]      imem_wdata;

    modport master (
        output in_valid, in_class, in_alu_op, in_reg, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_class, in_alu_op, in_reg, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder_field.sv
// Maps one set of symbolic fields to a 16-bit instruction word plus an illegal flag.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is used.
module instr_field_encoder
    import asip_isa_pkg::*;
(
    input  instr_class_e      cls,
    input  logic [2:0]        alu_op,
    input  logic [3:0]        reg_idx,
    input  logic [IMM_MSB:0]  imm,
    output logic [OPC_MSB:0]  word,
    output logic              illegal
);
    logic [3:0] opc;

    always_comb begin
        opc     = OP_LDI;
        illegal = 1'b0;
        case (cls)
            CLS_LDI:   opc = OP_LDI;
            CLS_ALU: begin
                opc     = {1'b0, alu_op};
                // alu_op 000 would produce the LDI opcode
                illegal = (alu_op == 3'b000);
            end
            CLS_JMP:   opc = OP_JMP;
            CLS_JCOND: opc = OP_JCOND;
            CLS_STORE: opc = OP_STORE;
            CLS_LOAD:  opc = OP_LOAD;
            CLS_HALT:  opc = OP_HALT;
            default:   illegal = 1'b1;
        endcase
        word = pack_word(opc, reg_idx, imm);
    end
endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes field beats into instruction words and writes a burst into instruction memory.
// Latency: handshake edge -> imem_we the next cycle; one legal word every 2 cycles.
// Backpressure: in_ready only in RUN; illegal beats are accepted and dropped. Macro ENCODER_CHECKSUM_EN adds an XOR checksum output.
module instr_stream_encoder
    import asip_isa_pkg::*;
#(
    parameter int N      = 16,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      word_count,
    instr_stream_encoder_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_illegal,
    output logic [ADDR_W-1:0]    err_count
`ifdef ENCODER_CHECKSUM_EN
    ,
    output logic [N-1:0]         checksum
`endif
);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ERR_MAX = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic [ADDR_W:0]   remaining_q;
    logic              err_illegal_q;
    logic [ADDR_W-1:0] err_count_q;

    logic [OPC_MSB:0]  enc_word;
    logic              enc_illegal;
    logic              accept;
    logic              in_ready_c;
    logic              imem_we_c;

    instr_field_encoder u_field (
        .cls     (instr_class_e'(bus.in_class)),
        .alu_op  (bus.in_alu_op),
        .reg_idx (bus.in_reg),
        .imm     (bus.in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept = (state_q == ST_RUN) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        imem_we_c  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (word_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && !enc_illegal) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                imem_we_c = 1'b1;
                state_d   = (remaining_q == REM_ONE) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            remaining_q   <= '0;
            err_illegal_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q        <= base_addr;
                        remaining_q   <= word_count;
                        err_illegal_q <= 1'b0;
                        err_count_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (enc_illegal) begin
                            err_illegal_q <= 1'b1;
                            if (err_count_q != ERR_MAX) begin
                                err_count_q <= err_count_q + ADDR_W'(1);
                            end
                        end else begin
                            wdata_q <= N'(enc_word);
                        end
                    end
                end
                ST_WRITE: begin
                    // address wraps naturally at 2^ADDR_W
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - REM_ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef ENCODER_CHECKSUM_EN
    logic [N-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            checksum_q <= '0;
        end else if (state_q == ST_WRITE) begin
            checksum_q <= checksum_q ^ wdata_q;
        end
    end

    assign checksum = checksum_q;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.imem_we    = imem_we_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign err_illegal    = err_illegal_q;
    assign err_count      = err_count_q;

endmodule
